// File: rtl/pim_pkg.sv
// Shared constants, opcode/state enums and instruction field positions for the pim block.
// PIM_XOR_EN: when defined, opcode 010 dispatches as an XOR ALU operation instead of a no-op.
package pim_pkg;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int INSTR_W = 45;
    localparam int DEPTH   = 1024;

    localparam int OP_HI   = 44;
    localparam int OP_LO   = 42;
    localparam int SRC1_HI = 41;
    localparam int SRC1_LO = 32;
    localparam int SRC2_HI = 31;
    localparam int SRC2_LO = 22;
    localparam int DST_HI  = 21;
    localparam int DST_LO  = 12;
    localparam int DATA_HI = 31;
    localparam int DATA_LO = 0;

    typedef enum logic [2:0] {
        OP_READ  = 3'b000,
        OP_WRITE = 3'b001,
        OP_XOR   = 3'b010,
        OP_ADD   = 3'b100,
        OP_SUB   = 3'b101,
        OP_AND   = 3'b110,
        OP_OR    = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_FETCH_A,
        S_FETCH_B,
        S_EXEC,
        S_WB
    } state_e;

    // First state after accept; S_IDLE means the instruction is a no-op.
    function automatic state_e dispatch(input logic [2:0] opc);
        state_e nxt;
        nxt = S_IDLE;
        if (opc[2]) begin
            nxt = S_FETCH_A;
        end else begin
            case (opc)
                3'b000:  nxt = S_READ;
                3'b001:  nxt = S_WRITE;
`ifdef PIM_XOR_EN
                3'b010:  nxt = S_FETCH_A;
`endif
                default: nxt = S_IDLE;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pim_alu.sv
// Combinational 32-bit ALU for the pim block: ADD, SUB, AND, OR and XOR, wrapping modulo 2^32.
module pim_alu
    import pim_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  op_e               op,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        // NOTE: default assignment first so no path through the case can infer a latch.
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/pim.sv
// Processing-in-memory tile: 1024x32 memory with embedded ALU behind an edge-triggered enable/ready handshake.
// PIM_XOR_EN (see pim_pkg::dispatch) turns opcode 010 into an XOR memory-to-memory operation.
module pim
    import pim_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               operation_enable,
    output logic [DATA_W-1:0]  data_out,
    output logic               ready
);

    logic [DATA_W-1:0]  mem [DEPTH];

    state_e             state;
    logic               en_q;
    logic [INSTR_W-1:0] instr_q;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  res_q;
    logic [DATA_W-1:0]  alu_y;
    op_e                alu_op;

    logic [ADDR_W-1:0]  src1;
    logic [ADDR_W-1:0]  src2;
    logic [ADDR_W-1:0]  dst;
    logic               accept;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;

    assign src1   = instr_q[SRC1_HI:SRC1_LO];
    assign src2   = instr_q[SRC2_HI:SRC2_LO];
    assign dst    = instr_q[DST_HI:DST_LO];
    assign alu_op = op_e'(instr_q[OP_HI:OP_LO]);

    // Only a fresh 0->1 edge of enable seen while idle starts an operation.
    assign accept = operation_enable && !en_q && (state == S_IDLE);

    pim_alu u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (alu_op),
        .y  (alu_y)
    );

    // Write port is driven from state, so an async reset into S_IDLE cancels any pending write.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = src1;
        mem_wdata = instr_q[DATA_HI:DATA_LO];
        if (state == S_WRITE) begin
            mem_we = 1'b1;
        end else if (state == S_WB) begin
            mem_we    = 1'b1;
            mem_waddr = dst;
            mem_wdata = res_q;
        end
    end

    // NOTE: the memory array has no reset; its contents are undefined until written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            en_q     <= 1'b0;
            ready    <= 1'b1;
            data_out <= '0;
            instr_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
        end else begin
            en_q <= operation_enable;
            case (state)
                S_IDLE: begin
                    ready <= 1'b1;
                    if (accept) begin
                        instr_q <= instruction;
                        ready   <= 1'b0;
                        state   <= dispatch(instruction[OP_HI:OP_LO]);
                    end
                end
                S_READ: begin
                    data_out <= mem[src1];
                    ready    <= 1'b1;
                    state    <= S_IDLE;
                end
                S_WRITE: begin
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                S_FETCH_A: begin
                    a_q   <= mem[src1];
                    state <= S_FETCH_B;
                end
                S_FETCH_B: begin
                    b_q   <= mem[src2];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    res_q <= alu_y;
                    state <= S_WB;
                end
                S_WB: begin
                    data_out <= res_q;
                    ready    <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pim.sv
// Scoreboard bench for pim: the driver queues expected data_out per operation, a monitor pops on each ready rise.
module tb_pim;
    import pim_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] exp;
        bit          chk;
    } entry_t;

    logic        clk;
    logic        rst;
    logic [44:0] instruction;
    logic        operation_enable;
    logic [31:0] data_out;
    logic        ready;

    entry_t      sb_q[$];
    int          checks;
    int          fails;
    logic        ready_prev;

    pim dut (
        .clk              (clk),
        .rst              (rst),
        .instruction      (instruction),
        .operation_enable (operation_enable),
        .data_out         (data_out),
        .ready            (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [44:0] mk_rw(input logic [2:0] op, input logic [9:0] addr, input logic [31:0] data);
        return {op, addr, data};
    endfunction

    function automatic logic [44:0] mk_alu(input logic [2:0] op, input logic [9:0] s1, input logic [9:0] s2,
                                          input logic [9:0] d, input logic [11:0] junk);
        return {op, s1, s2, d, junk};
    endfunction

    // Waits for idle, issues one request with enable held for 'hold' edges, then waits for completion.
    task automatic issue(input logic [44:0] ins, input string name, input logic [31:0] exp,
                         input bit chk, input int hold);
        int n;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_timeout"}, {31'b0, ready}, 32'd1);
        instruction      = ins;
        operation_enable = 1'b1;
        sb_q.push_back('{name: name, exp: exp, chk: chk});
        @(negedge clk);
        check({name, "_busy"}, {31'b0, ready}, 32'd0);
        for (int i = 1; i < hold; i++) @(negedge clk);
        operation_enable = 1'b0;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_timeout"}, {31'b0, ready}, 32'd1);
    endtask

    // Monitor: each ready rise outside reset completes the oldest queued operation.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            ready_prev = ready;
        end else begin
            if (ready && !ready_prev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_completion: got %08h expected no output", data_out);
                end else begin
                    entry_t e;
                    e = sb_q.pop_front();
                    if (e.chk) check(e.name, data_out, e.exp);
                end
            end
            ready_prev = ready;
        end
    end

    initial begin
        logic [31:0] xor_exp;
        checks           = 0;
        fails            = 0;
        ready_prev       = 1'b1;
        instruction      = '0;
        operation_enable = 1'b0;
        rst              = 1'b1;
        #3 rst = 1'b0;
        #10;
        check("reset_ready", {31'b0, ready}, 32'd1);
        check("reset_data_out", data_out, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        issue(mk_rw(3'b001, 10'h000, 32'h7FFFFFFF), "wr_000", 32'h0, 1'b0, 1);
        issue(mk_rw(3'b001, 10'h001, 32'h80000000), "wr_001", 32'h0, 1'b0, 1);
        issue(mk_rw(3'b001, 10'h002, 32'h00000000), "wr_002", 32'h0, 1'b0, 1);
        issue(mk_rw(3'b001, 10'h003, 32'hFFFFFFFF), "wr_003", 32'h0, 1'b0, 1);
        issue(mk_rw(3'b001, 10'h004, 32'h00000001), "wr_004", 32'h0, 1'b0, 1);
        issue(mk_rw(3'b001, 10'h3FF, 32'h12345678), "wr_3ff", 32'h0, 1'b0, 1);

        issue(mk_rw(3'b000, 10'h000, 32'h0), "rd_000", 32'h7FFFFFFF, 1'b1, 1);
        issue(mk_rw(3'b000, 10'h001, 32'h0), "rd_001", 32'h80000000, 1'b1, 1);
        issue(mk_rw(3'b000, 10'h002, 32'h0), "rd_002", 32'h00000000, 1'b1, 1);
        issue(mk_rw(3'b000, 10'h003, 32'h0), "rd_003", 32'hFFFFFFFF, 1'b1, 1);
        issue(mk_rw(3'b000, 10'h004, 32'h0), "rd_004", 32'h00000001, 1'b1, 1);
        issue(mk_rw(3'b000, 10'h3FF, 32'h0), "rd_3ff", 32'h12345678, 1'b1, 1);

        issue(mk_alu(3'b100, 10'h000, 10'h004, 10'h010, 12'h000), "add_wrap", 32'h80000000, 1'b1, 1);
        issue(mk_rw(3'b000, 10'h010, 32'h0), "rd_010", 32'h80000000, 1'b1, 1);
        issue(mk_alu(3'b101, 10'h001, 10'h004, 10'h011, 12'h000), "sub_wrap", 32'h7FFFFFFF, 1'b1, 1);
        issue(mk_rw(3'b000, 10'h011, 32'h0), "rd_011", 32'h7FFFFFFF, 1'b1, 1);
        issue(mk_alu(3'b110, 10'h003, 10'h3FF, 10'h012, 12'hABC), "and_junk", 32'h12345678, 1'b1, 1);
        issue(mk_rw(3'b000, 10'h012, 32'h0), "rd_012", 32'h12345678, 1'b1, 1);
        issue(mk_alu(3'b111, 10'h002, 10'h3FF, 10'h013, 12'h5A5), "or_junk", 32'h12345678, 1'b1, 1);
        issue(mk_rw(3'b000, 10'h013, 32'h0), "rd_013", 32'h12345678, 1'b1, 1);

        issue(mk_alu(3'b011, 10'h003, 10'h3FF, 10'h015, 12'h000), "noop_011", 32'h12345678, 1'b1, 1);
`ifdef PIM_XOR_EN
        xor_exp = 32'hEDCBA987;
`else
        xor_exp = 32'h12345678;
`endif
        issue(mk_alu(3'b010, 10'h003, 10'h3FF, 10'h015, 12'h000), "op_010", xor_exp, 1'b1, 1);

        issue(mk_alu(3'b100, 10'h004, 10'h004, 10'h004, 12'h000), "add_hold_alias", 32'h00000002, 1'b1, 3);
        issue(mk_rw(3'b000, 10'h004, 32'h0), "rd_004_once", 32'h00000002, 1'b1, 1);

        // Abort an ADD into 0x014 during FETCH_B.
        issue(mk_rw(3'b001, 10'h014, 32'hCAFEF00D), "wr_014", 32'h0, 1'b0, 1);
        @(negedge clk);
        instruction      = mk_alu(3'b100, 10'h000, 10'h004, 10'h014, 12'h000);
        operation_enable = 1'b1;
        @(negedge clk);
        operation_enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready", {31'b0, ready}, 32'd1);
        check("abort_data_out", data_out, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(mk_rw(3'b000, 10'h014, 32'h0), "rd_014_after_abort", 32'hCAFEF00D, 1'b1, 1);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pim.md
# pim

Processing-in-memory block: a 1024 x 32-bit word memory with an embedded 32-bit ALU, driven by 45-bit instructions. It performs host reads and writes, and memory-to-memory ALU operations (ADD, SUB, AND, OR) without the operands leaving the block. It sits as a slave compute/memory tile behind a simple enable/ready handshake.

## Interface
- Parameters: none. Fixed sizes are 1024 words (10-bit address), 32-bit data and 45-bit instruction.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- instruction  in  45  instruction word, sampled when an operation is accepted.
- operation_enable  in  1  request strobe; a 0->1 transition starts one operation.
- data_out  out  32  result of the last READ or ALU operation; held until replaced.
- ready  out  1  high when idle and able to accept a request.

## Operation
- Opcode is instruction[44:42].
- 000 READ: address in [41:32]; data_out <= mem[addr].
- 001 WRITE: address in [41:32], data in [31:0]; mem[addr] <= data.
- 1xx ALU: src1 in [41:32], src2 in [31:22], dst in [21:12]; bits [11:0] are ignored.
  - mem[dst] <= mem[src1] op mem[src2], and data_out <= the same result.
  - op: 100 ADD, 101 SUB (src1 - src2), 110 AND, 111 OR.
- 010 and 011 are no-ops: the instruction is accepted, ready returns, memory and data_out are unchanged. See Configuration for the one exception.
- Arithmetic is modulo 2^32 with no flags; overflow and underflow wrap silently.
- src1, src2 and dst may alias one another. Operands are read before the writeback.
- Memory contents are not reset (undefined until written). Reset clears only control state and outputs.

## Timing
- Reset values: ready = 1, data_out = 0, FSM = IDLE, registered enable history = 0.
- Acceptance:
  - operation_enable is registered each cycle.
  - A request is accepted on the first rising edge where enable = 1, the registered previous enable = 0, and the FSM is IDLE.
  - Holding enable high across several edges yields exactly one operation.
  - A rising edge of enable while busy is ignored and is not queued.
- The instruction is latched on the accept edge and may change afterwards.
- FSM states: IDLE, READ, WRITE, FETCH_A, FETCH_B, EXEC, WB.
- READ path: IDLE -> READ -> IDLE. data_out is valid and ready is high 2 cycles after the accept edge.
- WRITE path: IDLE -> WRITE -> IDLE. The memory update is visible to a READ accepted 2 cycles after the accept edge.
- ALU path: IDLE -> FETCH_A -> FETCH_B -> EXEC -> WB -> IDLE. The result is written and ready is high 5 cycles after the accept edge.
- No-op path: IDLE -> IDLE; ready dips for 1 cycle.
- ready is low from the cycle after accept until the FSM returns to IDLE.
- Reset asserted mid-operation: the operation aborts immediately with no memory write, and the outputs take their reset values.

## Configuration
- PIM_XOR_EN defined: opcode 010 is an ALU operation in the ALU field format, computing mem[dst] <= mem[src1] ^ mem[src2] with the same 5-cycle latency.
- PIM_XOR_EN undefined: opcode 010 is a no-op.

## Structure
- Package pim_pkg holds:
  - constants ADDR_W = 10, DATA_W = 32, INSTR_W = 45, DEPTH = 1024;
  - an opcode enum (OP_READ, OP_WRITE, OP_XOR, OP_ADD, OP_SUB, OP_AND, OP_OR);
  - the FSM state enum;
  - instruction field bit positions.
- Sub-module pim_alu: purely combinational, taking 32-bit a and b plus the opcode and producing a 32-bit result.
- Memory is a synchronous-read register array in the top level, one write port, read through registered operand latches.

## Test plan
- Write 0x000=7FFFFFFF, 0x001=80000000, 0x002=00000000, 0x003=FFFFFFFF, 0x004=00000001, 0x3FF=12345678 -> reading back each address returns the identical value on data_out.
- ADD src1 0x000, src2 0x004, dst 0x010 -> reading 0x010 returns 80000000.
- SUB src1 0x001, src2 0x004, dst 0x011 -> reading 0x011 returns 7FFFFFFF.
- AND 0x003 & 0x3FF into 0x012 -> 12345678; OR 0x002 | 0x3FF into 0x013 -> 12345678; junk in bits [11:0] has no effect.
- Enable held high for 3 cycles on an ADD with dst == src1 (0x004 + 0x004) -> the operation runs once and 0x004 = 00000002, not 4.
- Assert rst during FETCH_B of an ALU operation -> dst is unchanged, ready = 1, data_out = 0; the next READ works normally.
